// File: rtl/mdu_issue_ctrl.sv
// EXE-stage initiator for the multiply/divide unit. Decodes HI/LO-class ops,
// drives the MDU request fields, owns the architectural HI/LO registers and
// returns MFHI/MFLO and GPR MUL results to the pipeline.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   IDLE   | nothing outstanding; requests may be issued
//   BG     | retired HI/LO op still computing in the MDU
//   MULG   | GPR MUL computing; instruction held in EXE until data_ok
module mdu_issue_ctrl #(
  parameter int OPC_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  input  logic [OPC_W-1:0] op_code,
  input  logic [31:0]      src_a,
  input  logic [31:0]      src_b,
  input  logic             flush,
  output logic             stall_o,
  output logic             gpr_valid,
  output logic [31:0]      gpr_data,
  output logic             mdu_req,
  output logic             mulr_req,
  output logic             mul_req,
  output logic             mul_sign,
  output logic             accum_req,
  output logic             accum_op,
  output logic             div_req,
  output logic             div_sign,
  output logic             mt_req,
  output logic             mt_dest,
  output logic             mdu_cancel,
  output logic [63:0]      mdu_oprand,
  output logic [63:0]      mdu_hilo,
  input  logic             mdu_oprand_ok,
  input  logic             mdu_data_ok,
  input  logic [1:0]       mdu_we,
  input  logic [63:0]      mdu_wdata
);

  localparam logic [OPC_W-1:0] OP_MULT  = OPC_W'(0);
  localparam logic [OPC_W-1:0] OP_MULTU = OPC_W'(1);
  localparam logic [OPC_W-1:0] OP_DIV   = OPC_W'(2);
  localparam logic [OPC_W-1:0] OP_DIVU  = OPC_W'(3);
  localparam logic [OPC_W-1:0] OP_MADD  = OPC_W'(4);
  localparam logic [OPC_W-1:0] OP_MADDU = OPC_W'(5);
  localparam logic [OPC_W-1:0] OP_MSUB  = OPC_W'(6);
  localparam logic [OPC_W-1:0] OP_MSUBU = OPC_W'(7);
  localparam logic [OPC_W-1:0] OP_MTHI  = OPC_W'(8);
  localparam logic [OPC_W-1:0] OP_MTLO  = OPC_W'(9);
  localparam logic [OPC_W-1:0] OP_MFHI  = OPC_W'(10);
  localparam logic [OPC_W-1:0] OP_MFLO  = OPC_W'(11);
  localparam logic [OPC_W-1:0] OP_MUL   = OPC_W'(12);

  typedef enum logic [1:0] {S_IDLE, S_BG, S_MULG} state_t;

  state_t      state, state_nxt;
  logic [31:0] hi, lo;

  logic is_mult, is_div, is_madd, is_msub, is_mt, is_mf, is_mul;
  logic is_bg_op, is_issue, live;

  assign is_mult  = (op_code == OP_MULT) | (op_code == OP_MULTU);
  assign is_div   = (op_code == OP_DIV)  | (op_code == OP_DIVU);
  assign is_madd  = (op_code == OP_MADD) | (op_code == OP_MADDU);
  assign is_msub  = (op_code == OP_MSUB) | (op_code == OP_MSUBU);
  assign is_mt    = (op_code == OP_MTHI) | (op_code == OP_MTLO);
  assign is_mf    = (op_code == OP_MFHI) | (op_code == OP_MFLO);
  assign is_mul   = (op_code == OP_MUL);
  assign is_bg_op = is_mult | is_div | is_madd | is_msub;
  assign is_issue = is_bg_op | is_mt | is_mul;
  // A flushed EXE slot behaves exactly like an empty one.
  assign live     = op_valid & ~flush;

  assign mdu_oprand = {src_b, src_a};
  assign mdu_hilo   = {hi, lo};

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic; a MUL flush abandons the GPR result, a BG op always completes.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (live & is_bg_op & mdu_oprand_ok)    state_nxt = S_BG;
        else if (live & is_mul & mdu_oprand_ok) state_nxt = S_MULG;
      end
      S_BG:    if (mdu_data_ok) state_nxt = S_IDLE;
      S_MULG:  if (flush | mdu_data_ok) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Request fields, stall, cancel and GPR return path.
  always_comb begin
    mdu_req    = live & is_issue & (state == S_IDLE);
    mul_req    = mdu_req & (is_mult | is_madd | is_msub | is_mul);
    mulr_req   = mdu_req & is_mul;
    mul_sign   = mdu_req & ((op_code == OP_MULT) | (op_code == OP_MADD) |
                            (op_code == OP_MSUB) | is_mul);
    accum_req  = mdu_req & (is_madd | is_msub);
    accum_op   = mdu_req & is_msub;
    div_req    = mdu_req & is_div;
    div_sign   = mdu_req & (op_code == OP_DIV);
    mt_req     = mdu_req & is_mt;
    mt_dest    = mdu_req & (op_code == OP_MTHI);
    stall_o    = 1'b0;
    gpr_valid  = 1'b0;
    gpr_data   = '0;
    mdu_cancel = 1'b0;
    case (state)
      S_IDLE: begin
        if (live & is_bg_op)  stall_o = ~mdu_oprand_ok;
        else if (live & is_mul) stall_o = 1'b1;
        else if (live & is_mf) begin
          gpr_valid = 1'b1;
          gpr_data  = (op_code == OP_MFHI) ? hi : lo;
        end
      end
      S_BG: begin
        if (live & is_mf & mdu_data_ok) begin
          // Bypass the word being committed this cycle.
          gpr_valid = 1'b1;
          if (op_code == OP_MFHI) gpr_data = mdu_we[1] ? mdu_wdata[63:32] : hi;
          else                    gpr_data = mdu_we[0] ? mdu_wdata[31:0]  : lo;
        end else if (live & (is_issue | is_mf)) begin
          stall_o = 1'b1;
        end
      end
      S_MULG: begin
        if (flush) mdu_cancel = 1'b1;
        else if (mdu_data_ok) begin
          gpr_valid = 1'b1;
          gpr_data  = mdu_wdata[31:0];
        end else begin
          stall_o = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // HI/LO commit: MTHI/MTLO write src_a, background ops write the MDU result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi <= '0;
      lo <= '0;
    end else if (mdu_req & is_mt & mdu_oprand_ok & mdu_data_ok) begin
      if (mdu_we[1]) hi <= src_a;
      if (mdu_we[0]) lo <= src_a;
    end else if ((state == S_BG) & mdu_data_ok) begin
      if (mdu_we[1]) hi <= mdu_wdata[63:32];
      if (mdu_we[0]) lo <= mdu_wdata[31:0];
    end
  end

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Bench for mdu_issue_ctrl: plays the MDU responder, keeps an arithmetic
// model of HI/LO and checks every pipeline-visible output.
module tb_mdu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid, flush;
  logic [3:0]  op_code;
  logic [31:0] src_a, src_b;
  logic        stall_o, gpr_valid;
  logic [31:0] gpr_data;
  logic        mdu_req, mulr_req, mul_req, mul_sign, accum_req, accum_op;
  logic        div_req, div_sign, mt_req, mt_dest, mdu_cancel;
  logic [63:0] mdu_oprand, mdu_hilo;
  logic        mdu_oprand_ok, mdu_data_ok;
  logic [1:0]  mdu_we;
  logic [63:0] mdu_wdata;

  int tests = 0;
  int fails = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  always #5 clk = ~clk;

  mdu_issue_ctrl #(.OPC_W(4)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_code(op_code),
    .src_a(src_a), .src_b(src_b), .flush(flush), .stall_o(stall_o),
    .gpr_valid(gpr_valid), .gpr_data(gpr_data), .mdu_req(mdu_req),
    .mulr_req(mulr_req), .mul_req(mul_req), .mul_sign(mul_sign),
    .accum_req(accum_req), .accum_op(accum_op), .div_req(div_req),
    .div_sign(div_sign), .mt_req(mt_req), .mt_dest(mt_dest),
    .mdu_cancel(mdu_cancel), .mdu_oprand(mdu_oprand), .mdu_hilo(mdu_hilo),
    .mdu_oprand_ok(mdu_oprand_ok), .mdu_data_ok(mdu_data_ok),
    .mdu_we(mdu_we), .mdu_wdata(mdu_wdata)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Arithmetic the MDU would produce, from the instruction semantics.
  function automatic logic [63:0] mdu_result(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [31:0] hi,
                                             input logic [31:0] lo);
    longint      sp;
    logic [63:0] up, acc;
    int          sa, sb;
    sa  = a;
    sb  = b;
    sp  = longint'(sa) * longint'(sb);
    up  = {32'd0, a} * {32'd0, b};
    acc = {hi, lo};
    case (op)
      4'd0, 4'd12: return 64'(sp);
      4'd1:        return up;
      4'd2:        return {32'(sa % sb), 32'(sa / sb)};
      4'd3:        return {a % b, a / b};
      4'd4:        return acc + 64'(sp);
      4'd5:        return acc + up;
      4'd6:        return acc - 64'(sp);
      4'd7:        return acc - up;
      default:     return 64'd0;
    endcase
  endfunction

  task automatic drive_quiet();
    op_valid = 0; flush = 0; op_code = 4'd15; src_a = '0; src_b = '0;
    mdu_oprand_ok = 0; mdu_data_ok = 0; mdu_we = 2'b00; mdu_wdata = '0;
  endtask

  // One instruction through EXE with the MDU answering after l1 / l2 cycles.
  // follow: 0 none, 1 MFHI, 2 MFLO issued behind a background op.
  // flush_at: cycle index after acceptance at which flush is raised (-1 none).
  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int l1, input int l2, input int follow, input int flush_at);
    logic [63:0] res;
    logic [31:0] exp_g;
    bit          done, fl;
    res  = mdu_result(op, a, b, m_hi, m_lo);
    done = 0;
    if (op == 4'd8 || op == 4'd9) begin
      @(posedge clk); #1;
      op_valid = 1; op_code = op; src_a = a; src_b = b; flush = 0;
      mdu_oprand_ok = 1; mdu_data_ok = 1; mdu_we = (op == 4'd8) ? 2'b10 : 2'b01;
      mdu_wdata = {$urandom, $urandom};
      @(negedge clk);
      chk("mt_req", {mdu_req, mt_req, mt_dest}, {2'b11, op == 4'd8});
      chk("mt_stall", stall_o, 0);
      chk("mt_oprand", mdu_oprand, {b, a});
      if (op == 4'd8) m_hi = a; else m_lo = a;
    end else if (op == 4'd10 || op == 4'd11) begin
      @(posedge clk); #1;
      op_valid = 1; op_code = op; src_a = a; src_b = b; flush = 0;
      @(negedge clk);
      chk("mf_gpr_valid", gpr_valid, 1);
      chk("mf_gpr_data", gpr_data, (op == 4'd10) ? m_hi : m_lo);
      chk("mf_stall", {stall_o, mdu_req}, 0);
    end else if (op <= 4'd7 || op == 4'd12) begin
      for (int k = 0; k <= l1; k++) begin
        @(posedge clk); #1;
        op_valid = 1; op_code = op; src_a = a; src_b = b; flush = 0;
        mdu_oprand_ok = (k == l1); mdu_data_ok = 0;
        @(negedge clk);
        chk("req", mdu_req, 1);
        chk("req_stall", stall_o, (op == 4'd12) ? 1'b1 : (k < l1));
        chk("req_gpr_valid", gpr_valid, 0);
        if (k == 0) begin
          chk("req_fields", {mul_req, mulr_req, mul_sign, accum_req, accum_op, div_req, div_sign, mt_req},
              {op inside {4'd0, 4'd1, 4'd4, 4'd5, 4'd6, 4'd7, 4'd12}, op == 4'd12,
               op inside {4'd0, 4'd4, 4'd6, 4'd12}, op inside {4'd4, 4'd5, 4'd6, 4'd7},
               op inside {4'd6, 4'd7}, op inside {4'd2, 4'd3}, op == 4'd2, 1'b0});
          chk("req_oprand", mdu_oprand, {b, a});
          chk("req_hilo", mdu_hilo, {m_hi, m_lo});
        end
      end
      exp_g = (follow == 1) ? res[63:32] : res[31:0];
      for (int j = 1; j <= l2; j++) begin
        if (!done) begin
          fl = (j == flush_at);
          @(posedge clk); #1;
          mdu_oprand_ok = 0; mdu_data_ok = (j == l2); mdu_we = 2'b11; mdu_wdata = res;
          flush = fl;
          if (op == 4'd12) begin
            op_valid = 1; op_code = op;
          end else begin
            op_valid = (follow != 0) && !fl;
            op_code = (follow == 1) ? 4'd10 : 4'd11;
          end
          @(negedge clk);
          chk("busy_no_req", mdu_req, 0);
          if (op == 4'd12) begin
            if (fl) begin
              chk("mulg_flush", {mdu_cancel, gpr_valid, stall_o}, 3'b100);
              done = 1;
            end else if (j == l2) begin
              chk("mulg_done", {mdu_cancel, gpr_valid, stall_o}, 3'b010);
              chk("mulg_data", gpr_data, res[31:0]);
            end else begin
              chk("mulg_wait", {mdu_cancel, gpr_valid, stall_o}, 3'b001);
            end
          end else begin
            chk("bg_no_cancel", mdu_cancel, 0);
            if (op_valid && j == l2) begin
              chk("bg_release", {gpr_valid, stall_o}, 2'b10);
              chk("bg_bypass", gpr_data, exp_g);
            end else if (op_valid) begin
              chk("bg_stall", {gpr_valid, stall_o}, 2'b01);
            end else begin
              chk("bg_empty", {gpr_valid, stall_o}, 2'b00);
            end
          end
        end
      end
      if (op != 4'd12) begin
        m_hi = res[63:32];
        m_lo = res[31:0];
      end
    end else begin
      @(posedge clk); #1;
      op_valid = 1; op_code = op; src_a = a; src_b = b; flush = 0;
      @(negedge clk);
      chk("noop", {mdu_req, stall_o, gpr_valid}, 0);
    end
    @(posedge clk); #1;
    drive_quiet();
    @(negedge clk);
    chk("idle_hilo", mdu_hilo, {m_hi, m_lo});
    chk("idle_quiet", {stall_o, mdu_cancel, gpr_valid}, 0);
  endtask

  initial begin
    logic [3:0]  rop;
    logic [31:0] ra, rb;
    int          rl2, rfl;

    rst = 0;
    drive_quiet();
    #12;
    chk("rst_outputs", {stall_o, gpr_valid, mdu_req, mdu_cancel, mt_req, mul_req}, 0);
    chk("rst_hilo", mdu_hilo, 64'd0);
    @(negedge clk);
    rst = 1;

    // MTHI then MFHI
    do_op(4'd8, 32'h0000_1234, 32'd0, 0, 1, 0, -1);
    chk("mthi_hilo", mdu_hilo, 64'h00001234_00000000);
    do_op(4'd10, 32'd0, 32'd0, 0, 1, 0, -1);

    // MULT -3 x 5, MFLO stalled behind it and released with the bypass
    do_op(4'd0, 32'hFFFF_FFFD, 32'd5, 1, 2, 2, -1);
    chk("mult_hilo", mdu_hilo, 64'hFFFFFFFF_FFFFFFF1);

    // MUL leaves HI/LO alone
    do_op(4'd8, 32'h55, 32'd0, 0, 1, 0, -1);
    do_op(4'd9, 32'h55, 32'd0, 0, 1, 0, -1);
    do_op(4'd12, 32'd7, 32'd6, 1, 2, 0, -1);
    chk("mul_hilo_kept", mdu_hilo, 64'h00000055_00000055);

    // MADD accumulates onto {HI,LO}
    do_op(4'd8, 32'd0, 32'd0, 0, 1, 0, -1);
    do_op(4'd9, 32'd10, 32'd0, 0, 1, 0, -1);
    do_op(4'd4, 32'd3, 32'd4, 0, 1, 0, -1);
    chk("madd_hilo", mdu_hilo, 64'd22);

    // flush in MULG cancels; flush in BG does not
    do_op(4'd12, 32'd7, 32'd6, 0, 4, 0, 2);
    chk("mul_flush_hilo", mdu_hilo, 64'd22);
    do_op(4'd3, 32'd100, 32'd7, 0, 3, 0, 1);
    chk("divu_hilo", mdu_hilo, 64'h00000002_0000000E);

    // flush of an IDLE request and of an MF
    @(posedge clk); #1;
    op_valid = 1; op_code = 4'd0; flush = 1; mdu_oprand_ok = 1;
    @(negedge clk);
    chk("idle_flush_req", {mdu_req, stall_o, gpr_valid}, 0);
    @(posedge clk); #1;
    op_code = 4'd11; mdu_oprand_ok = 0;
    @(negedge clk);
    chk("idle_flush_mf", {mdu_req, stall_o, gpr_valid}, 0);

    // stray data_ok with nothing outstanding must not touch HI/LO
    @(posedge clk); #1;
    drive_quiet();
    mdu_data_ok = 1; mdu_we = 2'b11; mdu_wdata = 64'hDEAD_BEEF_CAFE_F00D;
    @(posedge clk); #1;
    drive_quiet();
    @(negedge clk);
    chk("stray_data_ok", mdu_hilo, {m_hi, m_lo});

    // randomized sequence
    for (int n = 0; n < 60; n++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = $urandom;
      rb  = $urandom;
      if (rop == 4'd2 || rop == 4'd3) rb = $urandom_range(1, 1000);
      rl2 = $urandom_range(1, 3);
      rfl = -1;
      if (rop == 4'd12 && $urandom_range(0, 3) == 0) rfl = $urandom_range(1, rl2);
      do_op(rop, ra, rb, $urandom_range(0, 2), rl2, $urandom_range(0, 2), rfl);
    end

    // asynchronous reset while a background op is in flight
    do_op(4'd9, 32'h77, 32'd0, 0, 1, 0, -1);
    @(posedge clk); #1;
    op_valid = 1; op_code = 4'd0; src_a = 32'd3; src_b = 32'd4; mdu_oprand_ok = 1;
    @(posedge clk); #1;
    op_code = 4'd11; mdu_oprand_ok = 0;
    @(negedge clk);
    chk("pre_rst_stall", stall_o, 1);
    #2;
    rst = 0;
    #1;
    chk("async_rst_stall", stall_o, 0);
    chk("async_rst_hilo", mdu_hilo, 64'd0);
    m_hi = '0;
    m_lo = '0;
    @(negedge clk);
    drive_quiet();
    rst = 1;
    do_op(4'd11, 32'd0, 32'd0, 0, 1, 0, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
